// File: rtl/frame_fifo_if.sv
// Frame handshake bundle between the trace frame assembler, the frame FIFO and the serialiser.
// The master side produces frames and pop requests; the slave side is the FIFO.
interface frame_fifo_if;
    logic [127:0] FrameIn;
    logic         FrameInValid;
    logic [127:0] Frame;
    logic         FrameReady;
    logic         FrameNext;

    modport master (
        output FrameIn,
        output FrameInValid,
        output FrameNext,
        input  Frame,
        input  FrameReady
    );

    modport slave (
        input  FrameIn,
        input  FrameInValid,
        input  FrameNext,
        output Frame,
        output FrameReady
    );
endinterface

// File: rtl/frame_fifo.sv
// Trace frame FIFO with a registered show-ahead output stage and lost/total frame statistics.
// Optional macro FRAME_FIFO_FLUSH_EN adds a Flush input that empties the FIFO.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_EMPTY   | no frame presented; waits for FramesCnt > 0
// S_FETCH   | RAM read of the oldest frame into the output register
// S_PRESENT | Frame/FrameReady valid; a FrameNext pops it
module frame_fifo #(
    parameter int BUFFLENLOG2 = 9
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef FRAME_FIFO_FLUSH_EN
    input  logic                   Flush,
`endif
    frame_fifo_if.slave            bus,
    output logic [BUFFLENLOG2-1:0] FramesCnt,
    output logic [15:0]            LostFrames,
    output logic [31:0]            TotalFrames
);
    localparam int DEPTH = 1 << BUFFLENLOG2;
    localparam logic [BUFFLENLOG2-1:0] ONE = 1;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_FETCH,
        S_PRESENT
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [127:0]           r_ram [0:DEPTH-1];
    logic [BUFFLENLOG2-1:0] r_wr_ptr;
    logic [BUFFLENLOG2-1:0] r_rd_ptr;
    logic [BUFFLENLOG2-1:0] r_cnt;
    logic [15:0]            r_lost;
    logic [31:0]            r_total;
    logic [127:0]           r_frame;
    logic                   r_ready;

    logic w_flush;
    logic w_full;
    logic w_wr_acc;
    logic w_wr_lost;
    logic w_pop;
    logic w_load;

`ifdef FRAME_FIFO_FLUSH_EN
    assign w_flush = Flush;
`else
    assign w_flush = 1'b0;
`endif

    // Fullness is judged on the pre-edge count, so a write racing a pop while full is lost.
    assign w_full    = (r_cnt == '1);
    assign w_wr_acc  = bus.FrameInValid & ~w_full & ~w_flush;
    assign w_wr_lost = bus.FrameInValid & (w_full | w_flush);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (r_cnt != '0) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                w_load      = 1'b1;
                w_state_nxt = S_PRESENT;
            end
            S_PRESENT: begin
                if (bus.FrameNext) begin
                    w_pop       = 1'b1;
                    w_state_nxt = (r_cnt > ONE) ? S_FETCH : S_EMPTY;
                end
            end
            default: begin
                w_state_nxt = S_EMPTY;
            end
        endcase
        if (w_flush) begin
            w_state_nxt = S_EMPTY;
            w_load      = 1'b0;
            w_pop       = 1'b0;
        end
    end

    // RAM has no reset so it maps onto block memory.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_acc) begin
            r_ram[r_wr_ptr] <= bus.FrameIn;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_lost   <= '0;
            r_total  <= '0;
            r_frame  <= '0;
            r_ready  <= 1'b0;
        end else begin
            if (bus.FrameInValid) begin
                r_total <= r_total + 32'd1;
            end
            if (w_wr_lost && (r_lost != 16'hFFFF)) begin
                r_lost <= r_lost + 16'd1;
            end
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + ONE;
            end
            if (w_flush) begin
                r_rd_ptr <= r_wr_ptr;
                r_cnt    <= '0;
                r_ready  <= 1'b0;
            end else begin
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + ONE;
                end
                case ({w_wr_acc, w_pop})
                    2'b10:   r_cnt <= r_cnt + ONE;
                    2'b01:   r_cnt <= r_cnt - ONE;
                    default: r_cnt <= r_cnt;
                endcase
                if (w_load) begin
                    r_frame <= r_ram[r_rd_ptr];
                    r_ready <= 1'b1;
                end else if (w_pop) begin
                    r_ready <= 1'b0;
                end
            end
        end
    end

    assign bus.Frame      = r_frame;
    assign bus.FrameReady = r_ready;
    assign FramesCnt      = r_cnt;
    assign LostFrames     = r_lost;
    assign TotalFrames    = r_total;
endmodule

// File: tb/tb_frame_fifo.sv
// Directed bench for frame_fifo with an 8-entry RAM (7 usable frames).
// Flush checks are compiled in only when FRAME_FIFO_FLUSH_EN is defined.
module tb_frame_fifo;
    localparam int L = 3;

    logic         clk = 1'b0;
    logic         rst;
`ifdef FRAME_FIFO_FLUSH_EN
    logic         Flush;
`endif
    logic [L-1:0] FramesCnt;
    logic [15:0]  LostFrames;
    logic [31:0]  TotalFrames;
    int           n_tests = 0;
    int           n_fail  = 0;

    frame_fifo_if bus ();

    frame_fifo #(.BUFFLENLOG2(L)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef FRAME_FIFO_FLUSH_EN
        .Flush       (Flush),
`endif
        .bus         (bus),
        .FramesCnt   (FramesCnt),
        .LostFrames  (LostFrames),
        .TotalFrames (TotalFrames)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [127:0] v);
        bus.FrameIn      = v;
        bus.FrameInValid = 1'b1;
        tick();
        bus.FrameInValid = 1'b0;
    endtask

    task automatic pop();
        bus.FrameNext = 1'b1;
        tick();
        bus.FrameNext = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        bus.FrameIn      = '0;
        bus.FrameInValid = 1'b0;
        bus.FrameNext    = 1'b0;
`ifdef FRAME_FIFO_FLUSH_EN
        Flush            = 1'b0;
`endif
        do_reset();

        check("rst_ready", 128'(bus.FrameReady), 128'(0));
        check("rst_frame", bus.Frame, 128'h0);
        check("rst_cnt",   128'(FramesCnt), 128'(0));
        check("rst_lost",  128'(LostFrames), 128'(0));
        check("rst_total", 128'(TotalFrames), 128'(0));

        // single frame latency: write at t, presented after t+2
        wr(128'hA5);
        check("a5_cnt_t",     128'(FramesCnt), 128'(1));
        check("a5_ready_t",   128'(bus.FrameReady), 128'(0));
        tick();
        check("a5_ready_t1",  128'(bus.FrameReady), 128'(0));
        tick();
        check("a5_ready_t2",  128'(bus.FrameReady), 128'(1));
        check("a5_frame_t2",  bus.Frame, 128'hA5);
        check("a5_cnt_t2",    128'(FramesCnt), 128'(1));
        pop();
        check("a5_pop_ready", 128'(bus.FrameReady), 128'(0));
        check("a5_pop_cnt",   128'(FramesCnt), 128'(0));
        tick();
        tick();
        check("a5_idle_ready", 128'(bus.FrameReady), 128'(0));

        // pop request while nothing is presented is ignored
        pop();
        check("empty_pop_cnt",   128'(FramesCnt), 128'(0));
        check("empty_pop_ready", 128'(bus.FrameReady), 128'(0));

        // three frames, pops spaced 16 cycles
        wr(128'd1);
        wr(128'd2);
        wr(128'd3);
        check("seq_cnt3",   128'(FramesCnt), 128'(3));
        check("seq_frame1", bus.Frame, 128'd1);
        repeat (16) tick();
        check("seq_hold1",  bus.Frame, 128'd1);
        pop();
        check("seq_cnt2",   128'(FramesCnt), 128'(2));
        check("seq_rdy_p1", 128'(bus.FrameReady), 128'(0));
        tick();
        check("seq_rdy_f1", 128'(bus.FrameReady), 128'(1));
        repeat (15) tick();
        check("seq_frame2", bus.Frame, 128'd2);
        pop();
        check("seq_cnt1",   128'(FramesCnt), 128'(1));
        repeat (16) tick();
        check("seq_frame3", bus.Frame, 128'd3);
        pop();
        check("seq_cnt0",   128'(FramesCnt), 128'(0));
        repeat (16) tick();
        check("seq_ready0", 128'(bus.FrameReady), 128'(0));

        // overflow: 9 offered, 7 kept, 2 lost
        do_reset();
        for (int i = 0; i < 9; i++) begin
            wr(128'(8'h10 + i));
        end
        tick();
        check("ovf_cnt",   128'(FramesCnt), 128'(7));
        check("ovf_lost",  128'(LostFrames), 128'(2));
        check("ovf_total", 128'(TotalFrames), 128'(9));
        check("ovf_head",  bus.Frame, 128'h10);

        // write and pop together while full: write lost, count drops by one
        bus.FrameIn      = 128'hEE;
        bus.FrameInValid = 1'b1;
        bus.FrameNext    = 1'b1;
        tick();
        bus.FrameInValid = 1'b0;
        bus.FrameNext    = 1'b0;
        check("fullpop_lost",  128'(LostFrames), 128'(3));
        check("fullpop_cnt",   128'(FramesCnt), 128'(6));
        check("fullpop_total", 128'(TotalFrames), 128'(10));
        for (int i = 1; i < 7; i++) begin
            tick();
            check("drain_ready", 128'(bus.FrameReady), 128'(1));
            check("drain_frame", bus.Frame, 128'(8'h10 + i));
            pop();
            check("drain_rdy0",  128'(bus.FrameReady), 128'(0));
        end
        check("drain_cnt", 128'(FramesCnt), 128'(0));
        tick();
        tick();
        check("drain_empty", 128'(bus.FrameReady), 128'(0));

        // LostFrames saturation
        do_reset();
        for (int i = 0; i < 7; i++) begin
            wr(128'(i));
        end
        bus.FrameInValid = 1'b1;
        repeat (65535) tick();
        bus.FrameInValid = 1'b0;
        check("sat_pre_lost",  128'(LostFrames), 128'(16'hFFFF));
        check("sat_pre_total", 128'(TotalFrames), 128'(65542));
        wr(128'hBB);
        check("sat_lost",  128'(LostFrames), 128'(16'hFFFF));
        check("sat_total", 128'(TotalFrames), 128'(65543));
        check("sat_cnt",   128'(FramesCnt), 128'(7));

        // reset mid-operation wins over concurrent write and pop
        rst              = 1'b1;
        bus.FrameInValid = 1'b1;
        bus.FrameNext    = 1'b1;
        tick();
        rst              = 1'b0;
        bus.FrameInValid = 1'b0;
        bus.FrameNext    = 1'b0;
        check("mrst_cnt",   128'(FramesCnt), 128'(0));
        check("mrst_lost",  128'(LostFrames), 128'(0));
        check("mrst_total", 128'(TotalFrames), 128'(0));
        check("mrst_ready", 128'(bus.FrameReady), 128'(0));
        check("mrst_frame", bus.Frame, 128'h0);
        tick();
        tick();
        check("mrst_idle",  128'(bus.FrameReady), 128'(0));

`ifdef FRAME_FIFO_FLUSH_EN
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wr(128'(8'h41 + i));
        end
        tick();
        check("fl_pre_frame", bus.Frame, 128'h41);
        check("fl_pre_cnt",   128'(FramesCnt), 128'(4));
        Flush            = 1'b1;
        bus.FrameIn      = 128'h99;
        bus.FrameInValid = 1'b1;
        tick();
        Flush            = 1'b0;
        bus.FrameInValid = 1'b0;
        check("fl_cnt",   128'(FramesCnt), 128'(0));
        check("fl_ready", 128'(bus.FrameReady), 128'(0));
        check("fl_lost",  128'(LostFrames), 128'(1));
        check("fl_total", 128'(TotalFrames), 128'(5));
        tick();
        check("fl_idle",  128'(bus.FrameReady), 128'(0));
        wr(128'h77);
        check("fl_wr_cnt",    128'(FramesCnt), 128'(1));
        tick();
        check("fl_wr_rdy_t1", 128'(bus.FrameReady), 128'(0));
        tick();
        check("fl_wr_rdy_t2", 128'(bus.FrameReady), 128'(1));
        check("fl_wr_frame",  bus.Frame, 128'h77);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
